seq_shift32: RTL and testbench
==============================

SEQ_SHIFT32 -- requirements
Module: seq_shift32

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; only 32 is required to be supported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 start  input  1  request pulse; accepted only when busy=0.
REQ-005 x  input  32  operand, captured on accepted start.
REQ-006 amt  input  5  shift distance 0..31, captured on accepted start.
REQ-007 dir  input  1  0 = logical left (zero fill LSB); 1 = arithmetic right (replicate MSB), captured on accepted start.
REQ-008 busy  output  1  high whenever state is not IDLE.
REQ-009 done  output  1  single-cycle pulse marking y valid.
REQ-010 y  output  32  result register.

Function
REQ-011 FSM states SHALL be IDLE, SHIFT, DONE; encoding free.
REQ-012 IDLE: start=1 SHALL capture x into y, amt into a 5-bit down-counter, dir into a direction flag; next state SHIFT if amt!=0, else DONE.
REQ-013 SHIFT: each cycle y SHALL shift one bit per dir (left: y<={y[30:0],1'b0}; right: y<={y[31],y[31:1]}) and counter SHALL decrement by 1.
REQ-014 SHIFT: the cycle the counter decrements from 1 to 0, the state SHALL go to DONE; exactly amt single-bit shifts performed.
REQ-015 DONE: done=1 for exactly one cycle; next state IDLE unconditionally.
REQ-016 Latency: start accepted at edge N -> done high during cycle following edge N+amt+1; amt=0 -> done the cycle after acceptance with y=x.
REQ-017 y SHALL hold its final value from DONE until the next accepted start.
REQ-018 start while busy=1 (SHIFT or DONE) SHALL be ignored; x, amt, dir changes while busy SHALL have no effect.
REQ-019 start in the same cycle as DONE SHALL be ignored; a new start is accepted only from IDLE (earliest the cycle after done).
REQ-020 Right shift of a negative operand SHALL saturate toward 0xFFFFFFFF; right shift of a non-negative operand toward 0x00000000; left shift by 31 leaves only bit 31 from x[0].
REQ-021 No arithmetic overflow flag; bits shifted out SHALL be discarded.

Reset
REQ-022 rst=1 SHALL force state IDLE, y=0x00000000, counter=0, direction flag=0, busy=0, done=0 at the next rising edge.
REQ-023 rst SHALL take priority over start and over any in-progress SHIFT/DONE; an aborted operation SHALL produce no done pulse.
REQ-024 After rst deasserts, start SHALL be accepted on the first following edge.

Verification
REQ-025 x=0x80000000, amt=3, dir=1, start at edge 0 -> busy edges 1..4, done pulse after edge 4, y=0xF0000000.
REQ-026 x=0x7FFFFFF8, amt=3, dir=1 -> y=0x0FFFFFFF, done after amt+1 edges.
REQ-027 x=0x00000001, amt=31, dir=0 -> y=0x80000000, done exactly 32 edges after start.
REQ-028 x=0xDEADBEEF, amt=0, dir=1 -> done one edge after start, y=0xDEADBEEF.
REQ-029 x=0x0000000F, amt=4, dir=0 started; start pulsed with x=0xFFFFFFFF at edge 2 -> ignored, y=0x000000F0, single done pulse.
REQ-030 x=0x12345678, amt=10 started; rst asserted at edge 5 -> next edge y=0, busy=0, no done; subsequent start x=0x1, amt=1, dir=0 -> y=0x2.

Source files
------------

// File: rtl/seq_shift32_if.sv
// Handshake/bus bundle for the sequential shifter.
//   master: drives start, x, amt, dir; observes busy, done, y
//   slave : the shifter side (inverse directions)
interface seq_shift32_if #(
  parameter int unsigned WIDTH = 32
);
  localparam int unsigned AMT_W = $clog2(WIDTH);

  logic             start;
  logic [WIDTH-1:0] x;
  logic [AMT_W-1:0] amt;
  logic             dir;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] y;

  modport master (
    output start, x, amt, dir,
    input  busy, done, y
  );

  modport slave (
    input  start, x, amt, dir,
    output busy, done, y
  );
endinterface

// File: rtl/seq_shift32.sv
// Sequential barrel-less shifter: one bit of shift per clock.
// A start accepted in IDLE captures x/amt/dir, then the result register is
// shifted one position per cycle (logical left or arithmetic right) until
// amt shifts are done, after which done pulses for one cycle.
// Ports:
//   clk  - clock, all state on rising edge
//   rst  - synchronous active-high reset
//   bus  - seq_shift32_if.slave (start, x, amt, dir in; busy, done, y out)
module seq_shift32 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  seq_shift32_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] y_q,     y_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             dir_q,   dir_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          y_d     = bus.x;
          cnt_d   = bus.amt;
          dir_d   = bus.dir;
          state_d = (bus.amt != '0) ? SHIFT : DONE;
        end
      end

      SHIFT: begin
        // dir=1 replicates the sign bit, dir=0 zero-fills the LSB.
        if (dir_q) begin
          y_d = {y_q[WIDTH-1], y_q[WIDTH-1:1]};
        end else begin
          y_d = {y_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - CNT_W'(1);
        // Last shift happens on the 1 -> 0 decrement.
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end

      DONE: begin
        // Start is deliberately ignored here; a new request waits for IDLE.
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered, so decode them from the next state.
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State register with synchronous reset; reset aborts any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      y_q     <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.y    = y_q;

endmodule

// File: tb/tb_seq_shift32.sv
// Self-checking bench for seq_shift32: directed corner cases plus random
// operations compared against an arithmetic reference of the shift result
// and its cycle timing.
module tb_seq_shift32;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  seq_shift32_if #(.WIDTH(32)) bus ();

  seq_shift32 #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference result: plain shift operators on the captured operand.
  function automatic logic [31:0] ref_shift(input logic [31:0] xv, input logic [4:0] av,
                                            input logic dv);
    logic [31:0] r;
    if (dv) r = $signed(xv) >>> av;
    else    r = xv << av;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Issue one operation (caller is at a negedge with the DUT idle) and check
  // busy/done every cycle, the result at done, and the hold afterwards.
  // With noise set, start and the operands are scrambled while busy.
  task automatic do_op(input logic [31:0] xv, input logic [4:0] av, input logic dv,
                       input bit noise);
    logic [31:0] exp_y;
    exp_y = ref_shift(xv, av, dv);
    bus.start = 1'b1;
    bus.x     = xv;
    bus.amt   = av;
    bus.dir   = dv;
    step();
    for (int j = 0; j <= int'(av); j++) begin
      chk("busy_run", 32'(bus.busy), 32'd1);
      chk("done_timing", 32'(bus.done), 32'(j == int'(av)));
      if (j == int'(av)) chk("y_at_done", bus.y, exp_y);
      bus.start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.x     = $urandom;
      bus.amt   = 5'($urandom);
      bus.dir   = 1'($urandom);
      step();
    end
    chk("busy_idle", 32'(bus.busy), 32'd0);
    chk("done_once", 32'(bus.done), 32'd0);
    chk("y_after", bus.y, exp_y);
    bus.start = 1'b0;
    bus.x     = $urandom;
    step();
    chk("y_hold", bus.y, exp_y);
    chk("idle_stay", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.x     = 32'hA5A5_A5A5;
    bus.amt   = 5'd7;
    bus.dir   = 1'b1;
    @(negedge clk);
    bus.start = 1'b1;
    step();
    step();
    chk("rst_y", bus.y, 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    rst       = 1'b0;
    bus.start = 1'b0;
    step();

    // Directed corner cases.
    do_op(32'h8000_0000, 5'd3,  1'b1, 1'b0);
    do_op(32'h7FFF_FFF8, 5'd3,  1'b1, 1'b0);
    do_op(32'h0000_0001, 5'd31, 1'b0, 1'b0);
    do_op(32'hDEAD_BEEF, 5'd0,  1'b1, 1'b0);
    do_op(32'h0000_000F, 5'd4,  1'b0, 1'b1);
    do_op(32'hFFFF_FFFF, 5'd31, 1'b1, 1'b1);
    do_op(32'h4000_0000, 5'd31, 1'b1, 1'b1);

    // Reset in the middle of a long shift: no done, state cleared.
    bus.start = 1'b1;
    bus.x     = 32'h1234_5678;
    bus.amt   = 5'd10;
    bus.dir   = 1'b0;
    step();
    bus.start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("abort_busy", 32'(bus.busy), 32'd1);
      chk("abort_nodone", 32'(bus.done), 32'd0);
      step();
    end
    rst = 1'b1;
    step();
    chk("abort_y", bus.y, 32'h0);
    chk("abort_busy0", 32'(bus.busy), 32'd0);
    chk("abort_done0", 32'(bus.done), 32'd0);
    rst = 1'b0;
    // Start accepted on the first edge after reset release.
    do_op(32'h0000_0001, 5'd1, 1'b0, 1'b0);

    // Randomized operations with bus noise while busy.
    for (int n = 0; n < 60; n++) begin
      do_op($urandom, 5'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Absolute time bound so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish by 200000");
    $fatal(1);
  end

endmodule
